blackjack_auto_player: RTL and testbench
========================================

Name: blackjack_auto_player

Overview:
- Automated player that sits on the opposite side of the blackjack game core's player interface, driving the hit/stand decisions a human would otherwise give on ui_in.
- Answers each decision request from the game with exactly one hit or stand pulse, after a fixed think delay.
- Keeps saturating win/loss/push tallies from the game's round results.
- Used for self-play demos and long-run bench soaking of the game core.

Parameters:
- STAND_AT, 17: threshold policy; hit iff player_total < STAND_AT.
- THINK_CYCLES, 4: cycles spent in THINK; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  enable; low freezes the FSM, think counter and tallies.
- req_valid  in  1  game requests a decision; held high until the answer pulse. Inputs stay stable while high.
- player_total  in  5  current hand total, 0..31.
- player_soft  in  1  hand contains an ace counted as 11.
- dealer_up  in  4  dealer upcard: 1=ace, 2..10; 0 and 11..15 are invalid.
- hit_pulse  out  1  single-cycle hit command.
- stand_pulse  out  1  single-cycle stand command.
- busy  out  1  high in any state other than IDLE.
- result_valid  in  1  single-cycle round result strobe.
- result  in  2  00 loss, 01 win, 10 push, 11 ignored.
- wins  out  8  saturating win count.
- losses  out  8  saturating loss count.
- pushes  out  8  saturating push count.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, think counter=0, hit_pulse=0, stand_pulse=0, busy=0, wins=losses=pushes=0. Reset mid-THINK or mid-pulse drops the request silently; no pulse is emitted.
- States: IDLE, THINK, ANSWER, WAIT_DROP.
- IDLE: on req_valid=1, latch player_total, player_soft and dealer_up, load the counter with THINK_CYCLES-1, go to THINK.
- THINK: decrement each cycle.
  - If req_valid=0: abort to IDLE with no pulse.
  - At count 0: go to ANSWER.
- ANSWER: assert exactly one of hit_pulse/stand_pulse for one cycle, chosen from the latched inputs. Go to WAIT_DROP.
- WAIT_DROP: stay until req_valid=0, then go to IDLE. A still-high request is never answered twice.
- Latency: the pulse is high in the cycle THINK_CYCLES+1 edges after the edge that sampled req_valid high in IDLE.
- Decision, threshold policy: hit iff total < STAND_AT.
- Decision overrides:
  - total >= 21 always stands, including bust values 22..31.
  - An invalid dealer_up is treated as 10.
- Outputs are registered; hit_pulse and stand_pulse are never both 1.
- Tallies: on result_valid=1 with ena=1, increment the selected counter, saturating at 255. Tallies run in any FSM state and are independent of the FSM. result=11 is ignored.
- ena=0: hold all state. A pulse due in that cycle is deferred until ena returns.

Optional Feature:
- Macro: AUTO_PLAYER_BASIC_STRATEGY_EN.
- Defined: the basic-strategy table replaces the threshold policy.
  - Hard hand:
    - total <= 11: hit.
    - total 12: stand if upcard is 4..6, else hit.
    - total 13..16: stand if upcard is 2..6, else hit.
    - total >= 17: stand.
  - Soft hand:
    - total <= 17: hit.
    - total 18: hit if upcard is 9, 10 or ace, else stand.
    - total >= 19: stand.
- The >=21 override still applies. STAND_AT is unused.
- Undefined: threshold policy only; player_soft and dealer_up are latched but unused.

Decomposition:
- Shared package blackjack_pkg holds:
  - FSM state enum.
  - Result codes RES_LOSS, RES_WIN, RES_PUSH.
  - Upcard constants UP_ACE=1, UP_TEN=10.
  - BJ_LIMIT=21.
- One sub-module, blackjack_auto_policy: purely combinational. Maps latched total, soft and upcard to a hit decision. The macro-dependent logic lives there only.

Test Plan:
- Threshold policy (macro undefined), total=16, req_valid held high: hit_pulse for exactly 1 cycle, 5 cycles after req sampled; stand_pulse stays 0. With total=17: stand_pulse instead.
- Request held high for 20 cycles after the answer: exactly one pulse total. Drop the request, re-raise it: a second answer arrives after 5 more cycles.
- req_valid dropped on the 2nd THINK cycle: no pulse, busy=0 on the next cycle, FSM back in IDLE.
- Macro defined:
  - hard 12 vs upcard 4 → stand.
  - hard 12 vs upcard 2 → hit.
  - soft 18 vs ace → hit.
  - soft 18 vs 7 → stand.
  - total 25 → stand.
- 300 result_valid strobes with result=01 → wins=255 (saturated). Then one result=00 → losses=1. A result=11 strobe changes no counter.
- Assert rst for one cycle during THINK: no pulse, all outputs 0. A fresh request afterwards is answered normally.

Source files
------------

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared types and constants for the blackjack auto player
package blackjack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_THINK     = 2'd1,
        ST_ANSWER    = 2'd2,
        ST_WAIT_DROP = 2'd3
    } state_t;

    localparam logic [1:0] RES_LOSS = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_PUSH = 2'b10;

    localparam logic [3:0] UP_ACE   = 4'd1;
    localparam logic [3:0] UP_TEN   = 4'd10;
    localparam logic [4:0] BJ_LIMIT = 5'd21;

    // Invalid upcard codes (0, 11..15) are played as a ten.
    function automatic logic [3:0] norm_up(input logic [3:0] up);
        return ((up == 4'd0) || (up > UP_TEN)) ? UP_TEN : up;
    endfunction

endpackage

// File: rtl/blackjack_auto_policy.sv
// rtl/blackjack_auto_policy.sv - combinational hit/stand decision; AUTO_PLAYER_BASIC_STRATEGY_EN selects the basic-strategy table
module blackjack_auto_policy
    import blackjack_pkg::*;
#(
    parameter int STAND_AT = 17
) (
    input  logic [4:0] i_total,
    input  logic       i_soft,
    input  logic [3:0] i_up,
    output logic       o_hit
);

`ifdef AUTO_PLAYER_BASIC_STRATEGY_EN
    localparam int unused_stand_at = STAND_AT;

    logic [3:0] w_up;
    logic       w_table_hit;

    assign w_up = norm_up(i_up);

    always_comb begin
        w_table_hit = 1'b0;
        if (!i_soft) begin
            if (i_total <= 5'd11)
                w_table_hit = 1'b1;
            else if (i_total == 5'd12)
                w_table_hit = !((w_up >= 4'd4) && (w_up <= 4'd6));
            else if (i_total <= 5'd16)
                w_table_hit = !((w_up >= 4'd2) && (w_up <= 4'd6));
        end else begin
            if (i_total <= 5'd17)
                w_table_hit = 1'b1;
            else if (i_total == 5'd18)
                w_table_hit = (w_up >= 4'd9) || (w_up == UP_ACE);
        end
    end

    assign o_hit = (i_total < BJ_LIMIT) && w_table_hit;
`else
    logic w_unused;

    assign w_unused = ^{i_soft, i_up};
    assign o_hit    = (i_total < BJ_LIMIT) && (int'(i_total) < STAND_AT);
`endif

endmodule

// File: rtl/blackjack_auto_player.sv
// rtl/blackjack_auto_player.sv - automated blackjack player: answers decision requests and keeps result tallies
// Optional basic-strategy policy enabled by AUTO_PLAYER_BASIC_STRATEGY_EN.
module blackjack_auto_player
    import blackjack_pkg::*;
#(
    parameter int STAND_AT     = 17,
    parameter int THINK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_valid,
    input  logic [4:0] player_total,
    input  logic       player_soft,
    input  logic [3:0] dealer_up,
    output logic       hit_pulse,
    output logic       stand_pulse,
    output logic       busy,
    input  logic       result_valid,
    input  logic [1:0] result,
    output logic [7:0] wins,
    output logic [7:0] losses,
    output logic [7:0] pushes
);

    localparam logic [7:0] THINK_LOAD = 8'(THINK_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [4:0] r_total;
    logic       r_soft;
    logic [3:0] r_up;
    logic       r_hit;
    logic       r_stand;
    logic       r_busy;
    logic [7:0] r_wins;
    logic [7:0] r_losses;
    logic [7:0] r_pushes;
    logic       w_hit;

    blackjack_auto_policy #(
        .STAND_AT (STAND_AT)
    ) u_policy (
        .i_total (r_total),
        .i_soft  (r_soft),
        .i_up    (r_up),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_total <= 5'd0;
            r_soft  <= 1'b0;
            r_up    <= 4'd0;
            r_hit   <= 1'b0;
            r_stand <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Pulses last one cycle; a frozen ANSWER re-emits once ena returns.
            r_hit   <= 1'b0;
            r_stand <= 1'b0;
            if (ena) begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            r_total <= player_total;
                            r_soft  <= player_soft;
                            r_up    <= dealer_up;
                            r_cnt   <= THINK_LOAD;
                            r_state <= ST_THINK;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_THINK: begin
                        if (!req_valid) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == 8'd0) begin
                            r_state <= ST_ANSWER;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ST_ANSWER: begin
                        r_hit   <= w_hit;
                        r_stand <= !w_hit;
                        r_state <= ST_WAIT_DROP;
                    end
                    ST_WAIT_DROP: begin
                        if (!req_valid) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wins   <= 8'd0;
            r_losses <= 8'd0;
            r_pushes <= 8'd0;
        end else if (ena && result_valid) begin
            case (result)
                RES_WIN:  if (r_wins   != 8'hFF) r_wins   <= r_wins   + 8'd1;
                RES_LOSS: if (r_losses != 8'hFF) r_losses <= r_losses + 8'd1;
                RES_PUSH: if (r_pushes != 8'hFF) r_pushes <= r_pushes + 8'd1;
                default: ;
            endcase
        end
    end

    assign hit_pulse   = r_hit;
    assign stand_pulse = r_stand;
    assign busy        = r_busy;
    assign wins        = r_wins;
    assign losses      = r_losses;
    assign pushes      = r_pushes;

endmodule

// File: tb/tb_blackjack_auto_player.sv
// tb/tb_blackjack_auto_player.sv - randomized self-checking bench for blackjack_auto_player
module tb_blackjack_auto_player;

    localparam int STAND = 17;
    localparam int THINK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] player_total = 5'd0;
    logic       player_soft = 1'b0;
    logic [3:0] dealer_up = 4'd0;
    logic       hit_pulse;
    logic       stand_pulse;
    logic       busy;
    logic       result_valid = 1'b0;
    logic [1:0] result = 2'b00;
    logic [7:0] wins;
    logic [7:0] losses;
    logic [7:0] pushes;

    int checks = 0;
    int errors = 0;
    int m_wins = 0;
    int m_losses = 0;
    int m_pushes = 0;

    blackjack_auto_player #(
        .STAND_AT     (STAND),
        .THINK_CYCLES (THINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .req_valid    (req_valid),
        .player_total (player_total),
        .player_soft  (player_soft),
        .dealer_up    (dealer_up),
        .hit_pulse    (hit_pulse),
        .stand_pulse  (stand_pulse),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .wins         (wins),
        .losses       (losses),
        .pushes       (pushes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference decision, taken straight from the playing rules.
    function automatic bit ref_hit(input int t, input bit s, input int u);
        int up;
        up = (u >= 1 && u <= 10) ? u : 10;
        if (t >= 21) return 1'b0;
`ifdef AUTO_PLAYER_BASIC_STRATEGY_EN
        if (!s) begin
            if (t <= 11) return 1'b1;
            if (t == 12) return !(up >= 4 && up <= 6);
            if (t <= 16) return !(up >= 2 && up <= 6);
            return 1'b0;
        end
        if (t <= 17) return 1'b1;
        if (t == 18) return (up == 1 || up >= 9);
        return 1'b0;
`else
        return (t < STAND);
`endif
    endfunction

    // Pulse value encoded as {hit,stand}: 2 = hit, 1 = stand, 0 = none.
    task automatic do_req(input int t, input bit s, input int u, input bit exp_hit, input int hold);
        @(negedge clk);
        player_total = 5'(t);
        player_soft  = s;
        dealer_up    = 4'(u);
        req_valid    = 1'b1;
        for (int k = 0; k <= THINK + 1; k++) begin
            @(negedge clk);
            if (k <= THINK) check("think_quiet", {hit_pulse, stand_pulse}, 0);
            else            check("answer", {hit_pulse, stand_pulse}, exp_hit ? 2 : 1);
        end
        check("busy_answer", busy, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_quiet", {hit_pulse, stand_pulse}, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    task automatic strobe(input logic [1:0] r);
        @(negedge clk);
        result_valid = 1'b1;
        result       = r;
        case (r)
            2'b01: if (m_wins   < 255) m_wins++;
            2'b00: if (m_losses < 255) m_losses++;
            2'b10: if (m_pushes < 255) m_pushes++;
            default: ;
        endcase
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    initial begin
        int t, u;
        bit s;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hit", hit_pulse, 0);
        check("rst_stand", stand_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_tallies", {wins, losses, pushes}, 0);
        rst = 1'b0;

`ifdef AUTO_PLAYER_BASIC_STRATEGY_EN
        do_req(12, 0, 4, 1'b0, 2);
        do_req(12, 0, 2, 1'b1, 2);
        do_req(18, 1, 1, 1'b1, 2);
        do_req(18, 1, 7, 1'b0, 2);
        do_req(25, 0, 10, 1'b0, 2);
        do_req(16, 0, 0, 1'b1, 1);
`else
        do_req(16, 0, 10, 1'b1, 2);
        do_req(17, 0, 10, 1'b0, 2);
        do_req(21, 1, 5, 1'b0, 1);
        do_req(0, 0, 15, 1'b1, 1);
`endif
        // Long hold then re-raise: one answer per request.
        do_req(25, 1, 3, 1'b0, 20);
        do_req(10, 0, 6, ref_hit(10, 0, 6), 0);

        for (int n = 0; n < 40; n++) begin
            t = $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            u = $urandom_range(0, 15);
            do_req(t, s, u, ref_hit(t, s, u), $urandom_range(0, 6));
        end

        // Abort on the second THINK cycle.
        @(negedge clk);
        player_total = 5'd5;
        req_valid    = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_quiet", {hit_pulse, stand_pulse, busy}, 0);
        end

        // ena low for three edges during THINK delays the answer by three.
        @(negedge clk);
        player_total = 5'd8;
        req_valid    = 1'b1;
        for (int k = 0; k <= THINK + 4; k++) begin
            @(negedge clk);
            if (k == 1) ena = 1'b0;
            if (k == 4) ena = 1'b1;
            if (k <= THINK + 3) check("ena_quiet", {hit_pulse, stand_pulse}, 0);
            else                check("ena_answer", {hit_pulse, stand_pulse}, 2);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ena_idle", busy, 0);

        // Reset mid-THINK drops the request and clears the tallies.
        strobe(2'b10);
        @(negedge clk);
        player_total = 5'd19;
        req_valid    = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_wins = 0; m_losses = 0; m_pushes = 0;
        check("rst_outs", {hit_pulse, stand_pulse, busy}, 0);
        check("rst_push", pushes, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_quiet", {hit_pulse, stand_pulse}, 0);
        end
        do_req(19, 0, 9, ref_hit(19, 0, 9), 1);

        for (int n = 0; n < 300; n++) strobe(2'b01);
        check("wins_sat", wins, 255);
        check("wins_model", wins, m_wins);
        strobe(2'b00);
        check("losses_one", losses, 1);
        strobe(2'b11);
        check("ign_wins", wins, m_wins);
        check("ign_losses", losses, m_losses);
        check("ign_pushes", pushes, m_pushes);

        for (int n = 0; n < 40; n++) begin
            strobe(2'($urandom_range(0, 3)));
            check("tally_rand", {wins, losses, pushes}, {m_wins[7:0], m_losses[7:0], m_pushes[7:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
